alarm_controller: RTL and testbench

- Consumes the stored alarm hour/minute held in the 6-bit alarm registers and compares it with the running time-of-day.
- Drives the buzzer through a ring / snooze / stop state machine with ring timeout and a snooze limit.
- Sits between the time counters and alarm registers upstream and the buzzer/LED outputs downstream.

---
 rtl/alarm_controller.sv | 138 +++++++++++++
 tb/tb_alarm_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
//==============================================================================
// Module  : alarm_controller
// Brief   : Alarm compare plus ring / snooze / stop state machine for the buzzer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module alarm_controller #(
    parameter int unsigned SNOOZE_MIN     = 5,
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       alarm_reset,
    input  logic       tick_1hz,
    input  logic [5:0] cur_hr,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [5:0] alm_hr,
    input  logic [5:0] alm_min,
    input  logic       alarm_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       alarm_active,
    output logic       snoozing,
    output logic [2:0] snooze_count,
    output logic [1:0] state
);

    localparam logic [1:0] c_IDLE    = 2'b00;
    localparam logic [1:0] c_RINGING = 2'b01;
    localparam logic [1:0] c_SNOOZE  = 2'b10;
    localparam logic [1:0] c_DONE    = 2'b11;

    localparam logic [9:0] c_SNOOZE_SECS = 10'(SNOOZE_MIN * 60);
    localparam logic [9:0] c_RING_LIMIT  = 10'(RING_TIMEOUT_S);
    localparam logic [2:0] c_MAX_SNOOZE  = 3'(MAX_SNOOZE);

    logic [1:0] r_state;
    logic       r_buzzer;
    logic [2:0] r_snooze_count;
    logic [9:0] r_sec_cnt;
    logic       r_snz_prev;
    logic       r_stop_prev;

    logic       w_match;
    logic       w_snz_edge;
    logic       w_stop_edge;
    logic [9:0] w_sec_inc;

    assign w_match     = (cur_hr == alm_hr) && (cur_min == alm_min);
    assign w_snz_edge  = snooze_btn & ~r_snz_prev;
    assign w_stop_edge = stop_btn & ~r_stop_prev;
    assign w_sec_inc   = r_sec_cnt + 10'd1;

    // Branch order inside each state encodes the priority: enable, stop, snooze, tick.
    always_ff @(posedge clk or posedge alarm_reset) begin
        if (alarm_reset) begin
            r_state        <= c_IDLE;
            r_buzzer       <= 1'b0;
            r_snooze_count <= 3'd0;
            r_sec_cnt      <= 10'd0;
            r_snz_prev     <= 1'b0;
            r_stop_prev    <= 1'b0;
        end else begin
            r_snz_prev  <= snooze_btn;
            r_stop_prev <= stop_btn;
            if (!alarm_en) begin
                r_state        <= c_IDLE;
                r_buzzer       <= 1'b0;
                r_snooze_count <= 3'd0;
                r_sec_cnt      <= 10'd0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_buzzer <= 1'b0;
                        if (tick_1hz && w_match && (cur_sec == 6'd0)) begin
                            r_state   <= c_RINGING;
                            r_sec_cnt <= 10'd0;
                            r_buzzer  <= 1'b1;
                        end
                    end
                    c_RINGING: begin
                        if (w_stop_edge) begin
                            r_state  <= c_DONE;
                            r_buzzer <= 1'b0;
                        end else if (w_snz_edge && (r_snooze_count < c_MAX_SNOOZE)) begin
                            r_state        <= c_SNOOZE;
                            r_buzzer       <= 1'b0;
                            r_snooze_count <= r_snooze_count + 3'd1;
                            r_sec_cnt      <= c_SNOOZE_SECS;
                        end else if (tick_1hz) begin
                            r_sec_cnt <= w_sec_inc;
                            if (w_sec_inc == c_RING_LIMIT) begin
                                r_state  <= c_DONE;
                                r_buzzer <= 1'b0;
                            end else begin
                                r_buzzer <= ~r_buzzer;
                            end
                        end
                    end
                    c_SNOOZE: begin
                        r_buzzer <= 1'b0;
                        if (w_stop_edge) begin
                            r_state <= c_DONE;
                        end else if (tick_1hz) begin
                            if (r_sec_cnt == 10'd1) begin
                                r_state   <= c_RINGING;
                                r_sec_cnt <= 10'd0;
                                r_buzzer  <= 1'b1;
                            end else begin
                                r_sec_cnt <= r_sec_cnt - 10'd1;
                            end
                        end
                    end
                    default: begin
                        // Hold in DONE until the alarm minute has passed, so one trigger per minute.
                        r_buzzer <= 1'b0;
                        if (!w_match) begin
                            r_state        <= c_IDLE;
                            r_snooze_count <= 3'd0;
                        end
                    end
                endcase
            end
        end
    end

    assign buzzer       = r_buzzer;
    assign snooze_count = r_snooze_count;
    assign state        = r_state;
    assign alarm_active = (r_state == c_RINGING);
    assign snoozing     = (r_state == c_SNOOZE);

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
//==============================================================================
// Module  : tb_alarm_controller
// Brief   : Directed self-checking bench for alarm_controller.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [5:0] cur_hr = 6'd0, cur_min = 6'd0, cur_sec = 6'd0;
    logic [5:0] alm_hr = 6'd0, alm_min = 6'd0;
    logic       alarm_en = 1'b0, snooze_btn = 1'b0, stop_btn = 1'b0;
    logic       buzzer, alarm_active, snoozing;
    logic [2:0] snooze_count;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alarm_controller #(
        .SNOOZE_MIN    (1),
        .RING_TIMEOUT_S(5),
        .MAX_SNOOZE    (2)
    ) dut (
        .clk         (clk),
        .alarm_reset (rst),
        .tick_1hz    (tick),
        .cur_hr      (cur_hr),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .alm_hr      (alm_hr),
        .alm_min     (alm_min),
        .alarm_en    (alarm_en),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .buzzer      (buzzer),
        .alarm_active(alarm_active),
        .snoozing    (snoozing),
        .snooze_count(snooze_count),
        .state       (state)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic tick_full();
        pulse();
        repeat (9) @(negedge clk);
    endtask

    task automatic trigger();
        cur_hr = 6'd7; cur_min = 6'd30; cur_sec = 6'd0;
        pulse();
        cur_sec = 6'd1;
    endtask

    task automatic press_snooze();
        snooze_btn = 1'b1;
        @(negedge clk);
        snooze_btn = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_state", 16'(state), 16'h0);
        chk("rst_buzzer", 16'(buzzer), 16'h0);
        chk("rst_count", 16'(snooze_count), 16'h0);
        chk("rst_flags", {14'd0, alarm_active, snoozing}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        alm_hr = 6'd7; alm_min = 6'd30; alarm_en = 1'b1;
        cur_hr = 6'd7; cur_min = 6'd29; cur_sec = 6'd59;
        repeat (3) @(negedge clk);

        // Trigger and timeout
        tick_full();
        chk("pre_trigger", 16'(state), 16'h0);
        trigger();
        chk("trig_state", 16'(state), 16'h1);
        chk("trig_buzzer", 16'(buzzer), 16'h1);
        chk("trig_active", 16'(alarm_active), 16'h1);
        repeat (9) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            tick_full();
            chk("ring_buzzer", 16'(buzzer), 16'((i % 2) == 0));
            chk("ring_state", 16'(state), 16'h1);
        end
        pulse();
        chk("timeout_state", 16'(state), 16'h3);
        chk("timeout_buzzer", 16'(buzzer), 16'h0);
        repeat (5) @(negedge clk);
        chk("done_hold", 16'(state), 16'h3);
        cur_min = 6'd31;
        @(negedge clk);
        chk("done_exit", 16'(state), 16'h0);

        // Snooze cycles and snooze limit
        trigger();
        repeat (4) @(negedge clk);
        press_snooze();
        chk("snz1_state", 16'(state), 16'h2);
        chk("snz1_count", 16'(snooze_count), 16'h1);
        chk("snz1_buzzer", 16'(buzzer), 16'h0);
        chk("snz1_flag", 16'(snoozing), 16'h1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 59; i++) tick_full();
        chk("snz1_59", 16'(state), 16'h2);
        pulse();
        chk("snz1_wake", 16'(state), 16'h1);
        chk("snz1_wake_bz", 16'(buzzer), 16'h1);
        repeat (4) @(negedge clk);
        press_snooze();
        chk("snz2_state", 16'(state), 16'h2);
        chk("snz2_count", 16'(snooze_count), 16'h2);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 60; i++) tick_full();
        chk("snz2_wake", 16'(state), 16'h1);
        press_snooze();
        chk("snz3_ignored", 16'(state), 16'h1);
        chk("snz3_count", 16'(snooze_count), 16'h2);
        chk("snz3_buzzer", 16'(buzzer), 16'h1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) tick_full();
        chk("snz_ring4", 16'(state), 16'h1);
        pulse();
        chk("snz_timeout", 16'(state), 16'h3);
        chk("snz_done_cnt", 16'(snooze_count), 16'h2);
        cur_min = 6'd31;
        @(negedge clk);
        chk("snz_exit", 16'(state), 16'h0);
        chk("snz_exit_cnt", 16'(snooze_count), 16'h0);

        // Stop and snooze together
        trigger();
        repeat (4) @(negedge clk);
        stop_btn = 1'b1; snooze_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0; snooze_btn = 1'b0;
        chk("both_state", 16'(state), 16'h3);
        chk("both_count", 16'(snooze_count), 16'h0);
        cur_min = 6'd31;
        @(negedge clk);
        chk("both_exit", 16'(state), 16'h0);

        // Enable dropped during snooze
        trigger();
        repeat (4) @(negedge clk);
        press_snooze();
        chk("en_snz", 16'(state), 16'h2);
        repeat (3) tick_full();
        alarm_en = 1'b0;
        @(negedge clk);
        chk("en_off_state", 16'(state), 16'h0);
        chk("en_off_count", 16'(snooze_count), 16'h0);
        alarm_en = 1'b1;
        cur_sec = 6'd5;
        repeat (2) tick_full();
        chk("en_no_retrig", 16'(state), 16'h0);

        // Asynchronous reset mid-ring with a nonzero snooze count
        trigger();
        repeat (4) @(negedge clk);
        press_snooze();
        repeat (5) @(negedge clk);
        for (int i = 0; i < 60; i++) tick_full();
        chk("ar_ring", 16'(state), 16'h1);
        chk("ar_count", 16'(snooze_count), 16'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_state", 16'(state), 16'h0);
        chk("ar_buzzer", 16'(buzzer), 16'h0);
        chk("ar_cnt0", 16'(snooze_count), 16'h0);
        snooze_btn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("ar_release", 16'(state), 16'h0);
        snooze_btn = 1'b0;
        @(negedge clk);

        // Alarm registers reloaded during ringing
        trigger();
        chk("rl_ring", 16'(state), 16'h1);
        alm_hr = 6'd8; alm_min = 6'd0;
        repeat (9) @(negedge clk);
        for (int i = 0; i < 4; i++) tick_full();
        chk("rl_still", 16'(state), 16'h1);
        pulse();
        chk("rl_done", 16'(state), 16'h3);
        @(negedge clk);
        chk("rl_idle", 16'(state), 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
